sram_multiplier_system: RTL and testbench

SRAM_MULTIPLIER_SYSTEM -- requirements
Module: sram_multiplier_system

---
 rtl/sram_multiplier_system.sv | 66 ++++++
 tb/tb_sram_multiplier_system.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sram_multiplier_system.sv
// Word store loaded once after reset, then streamed against data_in:
// each compute cycle multiplies data_in by the next stored word (unsigned, full width).
module sram_multiplier_system #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_COUNT = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MULT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_ce,
  input  logic                  init_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [MULT_WIDTH-1:0] data_out,
  output logic                  init_done,
  output logic                  valid_out
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_COUNT - 1);

  logic [DATA_WIDTH-1:0] mem [ADDR_COUNT];
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  load_en;
  logic                  compute_en;
  logic [MULT_WIDTH-1:0] product;

  always_comb begin
    load_en    = pe_ce & init_enable & ~init_done;
    compute_en = pe_ce & init_done & ~init_enable;
    product    = MULT_WIDTH'(data_in) * MULT_WIDTH'(mem[rd_addr]);
  end

  // Memory is never cleared; the rst_n gate only keeps reset dominant over a write.
  always_ff @(posedge clk) begin
    if (rst_n && load_en)
      mem[wr_addr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      rd_addr   <= '0;
      init_done <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (pe_ce) begin
      valid_out <= 1'b0;
      if (load_en) begin
        if (wr_addr == LAST_ADDR) begin
          wr_addr   <= '0;
          init_done <= 1'b1;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end else if (compute_en) begin
        data_out  <= product;
        valid_out <= 1'b1;
        rd_addr   <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
      end
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_multiplier_system.sv
// Directed and randomized checks of sram_multiplier_system against a
// word-list reference model (load list, then cycle through it multiplying).
module tb_sram_multiplier_system;

  localparam int DW = 16;
  localparam int N  = 32;
  localparam int MW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pe_ce = 1'b0;
  logic          init_enable = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [MW-1:0] data_out;
  logic          init_done;
  logic          valid_out;

  sram_multiplier_system #(
    .DATA_WIDTH(DW),
    .ADDR_COUNT(N),
    .ADDR_WIDTH(5),
    .MULT_WIDTH(MW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pe_ce      (pe_ce),
    .init_enable(init_enable),
    .data_in    (data_in),
    .data_out   (data_out),
    .init_done  (init_done),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  // reference model state
  int unsigned   words [N];
  int unsigned   n_loaded;
  int unsigned   next_word;
  bit            m_done;
  bit            m_valid;
  longint unsigned m_dout;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ce, input bit ie, input int unsigned din);
    rst_n = r; pe_ce = ce; init_enable = ie; data_in = DW'(din);
    @(posedge clk);
    #1;
    if (!r) begin
      n_loaded = 0; next_word = 0; m_done = 0; m_valid = 0; m_dout = 0;
    end else if (!ce) begin
      m_valid = 0;
    end else if (ie && !m_done) begin
      words[n_loaded] = din & 16'hFFFF;
      n_loaded = n_loaded + 1;
      if (n_loaded == N) begin
        n_loaded = 0;
        m_done = 1;
      end
      m_valid = 0;
    end else if (!ie && m_done) begin
      m_dout = longint'(din & 16'hFFFF) * longint'(words[next_word]);
      next_word = (next_word + 1) % N;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    check("valid_out", MW'(valid_out), MW'(m_valid));
    check("init_done", MW'(init_done), MW'(m_done));
    check("data_out", data_out, MW'(m_dout));
  endtask

  initial begin
    n_loaded = 0; next_word = 0; m_done = 0; m_valid = 0; m_dout = 0;

    // reset, with reset dominating an active load request
    step(0, 1, 1, 16'h1234);
    step(0, 0, 0, 0);

    // sequential load k+1, then data_in=2 gives 2,4,...,64
    for (int k = 0; k < N; k++) step(1, 1, 1, k + 1);
    for (int k = 0; k < N; k++) begin
      step(1, 1, 0, 2);
      check("seq_product", data_out, MW'(2 * (k + 1)));
    end

    // writes ignored once loaded; then wrap: 33 computes with data_in=1
    for (int k = 0; k < 3; k++) step(1, 1, 1, 16'hDEAD);
    for (int k = 0; k < N + 1; k++) step(1, 1, 0, 1);
    check("wrap_product", data_out, MW'(1));

    // reset mid-compute then full-scale load: no truncation
    step(1, 1, 0, 5);
    step(0, 1, 0, 0);
    for (int k = 0; k < N; k++) step(1, 1, 1, 16'hFFFF);
    step(1, 1, 0, 16'hFFFF);
    check("max_product", data_out, 32'hFFFE0001);

    // paused load: 10 words, 5 idle cycles (one with pe_ce low), 22 words
    step(0, 1, 1, 0);
    for (int k = 0; k < 10; k++) step(1, 1, 1, $urandom_range(0, 16'hFFFF));
    for (int k = 0; k < 4; k++) step(1, 1, 0, $urandom_range(0, 16'hFFFF));
    step(1, 0, 1, 16'hBEEF);
    for (int k = 0; k < 22; k++) step(1, 1, 1, $urandom_range(0, 16'hFFFF));
    check("done_after_32", MW'(init_done), MW'(1));

    // compute with a 3-cycle chip-enable gap mid-sequence
    for (int k = 0; k < 7; k++) step(1, 1, 0, $urandom_range(0, 16'hFFFF));
    for (int k = 0; k < 3; k++) step(1, 0, 0, $urandom_range(0, 16'hFFFF));
    for (int k = 0; k < N; k++) step(1, 1, 0, $urandom_range(0, 16'hFFFF));

    // reset mid-load aborts; three random reset/load/compute passes
    step(0, 1, 1, 0);
    for (int k = 0; k < 5; k++) step(1, 1, 1, $urandom_range(0, 16'hFFFF));
    for (int p = 0; p < 3; p++) begin
      step(0, 1, 0, 0);
      check("done_cleared", MW'(init_done), MW'(0));
      for (int k = 0; k < N; k++) step(1, 1, 1, $urandom_range(0, 16'hFFFF));
      for (int k = 0; k < N; k++) step(1, 1, 0, $urandom_range(0, 16'hFFFF));
      step(1, 1, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
